// File: rtl/serial_addsub_pkg.sv
// Shared state encoding and mode constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/full_addsub_cell.sv
// One-bit full adder / full subtractor; mode selects carry or borrow generation.
module full_addsub_cell
    import serial_addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);

    always_comb begin
        s = a ^ b ^ cin;
        if (mode == MODE_ADD) begin
            cout = (a & b) | (cin & (a ^ b));
        end else begin
            cout = (~a & b) | (~(a ^ b) & cin);
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/sub: one bit per clock, LSB first, through a single cell.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cb_out,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh, b_sh, acc;
    logic               mode_q;
    logic               c;
    logic               accept, last;
    logic               s_bit, c_next;

    full_addsub_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .mode (mode_q),
        .s    (s_bit),
        .cout (c_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // DONE accepts start just like IDLE so back-to-back ops need no bubble.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_BIT) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            mode_q <= MODE_SUB;
            c      <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cb_out <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_q <= mode;
            c      <= 1'b0;
            cnt    <= '0;
        end else if (state_q == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            acc  <= {s_bit, acc[WIDTH-1:1]};
            c    <= c_next;
            cnt  <= cnt + CNT_W'(1);
            // On the last bit a_sh[0]/b_sh[0] are the operand sign bits.
            if (last) begin
                result <= {s_bit, acc[WIDTH-1:1]};
                cb_out <= c_next;
                if (mode_q == MODE_ADD)
                    ovf <= (a_sh[0] == b_sh[0]) && (s_bit != a_sh[0]);
                else
                    ovf <= (a_sh[0] != b_sh[0]) && (s_bit != a_sh[0]);
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench: WIDTH=8 directed/random ops plus WIDTH=4 exhaustive sweep.
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, start8, mode8, busy8, done8, cb8, ovf8;
    logic [7:0] a8, b8, res8;
    logic       rst4, start4, mode4, busy4, done4, cb4, ovf4;
    logic [3:0] a4, b4, res4;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cb_out(cb8), .ovf(ovf8)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .cb_out(cb4), .ovf(ovf4)
    );

    int tests = 0;
    int failed = 0;
    logic [33:0] q8[$];
    logic [33:0] q4[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, packed as {ovf, cb, result[31:0]}.
    function automatic logic [33:0] model(input int w, input bit m, input longint x, input longint y);
        longint mask, full, sx, sy, v, lo, hi;
        logic [33:0] r;
        mask = (longint'(1) << w) - 1;
        sx = (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
        sy = (y >= (longint'(1) << (w - 1))) ? y - (longint'(1) << w) : y;
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        if (m) begin
            full = x + y;
            v = sx + sy;
            r[32] = ((full >> w) & 1) != 0;
        end else begin
            full = x - y;
            v = sx - sy;
            r[32] = (x < y);
        end
        r[31:0] = 32'(full & mask);
        r[33] = (v < lo) || (v > hi);
        return r;
    endfunction

    always @(negedge clk) begin : mon8
        logic [33:0] e;
        if (!rst8 && done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 32'(done8), 32'd0);
            end else begin
                e = q8.pop_front();
                check("result8", 32'(res8), e[31:0]);
                check("cb_out8", 32'(cb8), 32'(e[32]));
                check("ovf8", 32'(ovf8), 32'(e[33]));
            end
        end
    end

    always @(negedge clk) begin : mon4
        logic [33:0] e;
        if (!rst4 && done4) begin
            if (q4.size() == 0) begin
                check("unexpected_done4", 32'(done4), 32'd0);
            end else begin
                e = q4.pop_front();
                check("result4", 32'(res4), e[31:0]);
                check("cb_out4", 32'(cb4), 32'(e[32]));
                check("ovf4", 32'(ovf4), 32'(e[33]));
            end
        end
    end

    // Waits for !busy at a negedge (IDLE or DONE), then drives start for one edge.
    task automatic issue8(input bit m, input logic [7:0] x, input logic [7:0] y, input logic [33:0] exp);
        int t = 0;
        @(negedge clk);
        while (busy8 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("issue8_timeout", 32'(busy8), 32'd0);
        start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
        q8.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0;
        check("busy_after_start8", 32'(busy8), 32'd1);
    endtask

    task automatic issue4(input bit m, input logic [3:0] x, input logic [3:0] y, input logic [33:0] exp);
        int t = 0;
        @(negedge clk);
        while (busy4 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("issue4_timeout", 32'(busy4), 32'd0);
        start4 = 1'b1; mode4 = m; a4 = x; b4 = y;
        q4.push_back(exp);
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    function automatic logic [33:0] pk(input bit o, input bit cb, input logic [7:0] r);
        return {o, cb, 24'd0, r};
    endfunction

    initial begin
        int k;
        int t;
        rst8 = 1'b1; start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
        rst4 = 1'b1; start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
        #12;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_result", 32'(res8), 32'd0);
        check("rst_cb", 32'(cb8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        @(negedge clk); rst8 = 1'b0; rst4 = 1'b0;

        // 5-3 with latency measurement: start edge plus WIDTH edges.
        issue8(1'b0, 8'd5, 8'd3, pk(0, 0, 8'h02));
        k = 0;
        while (!done8 && k < 50) begin @(posedge clk); #1; k++; end
        check("latency_edges", 32'(k + 1), 32'd9);

        issue8(1'b0, 8'd3, 8'd5, pk(0, 1, 8'hFE));
        issue8(1'b0, 8'h80, 8'h01, pk(1, 0, 8'h7F));
        issue8(1'b1, 8'hFF, 8'h01, pk(0, 1, 8'h00));
        issue8(1'b1, 8'h7F, 8'h01, pk(1, 0, 8'h80));
        issue8(1'b0, 8'h5A, 8'h5A, pk(0, 0, 8'h00));
        issue8(1'b0, 8'h00, 8'hFF, pk(0, 1, 8'h01));

        // Start pulsed mid-RUN with other operands must be ignored.
        issue8(1'b0, 8'd5, 8'd3, pk(0, 0, 8'h02));
        repeat (2) @(posedge clk);
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b1; a8 = 8'hAA; b8 = 8'h33;
        @(posedge clk); #1; start8 = 1'b0;

        // Back-to-back via DONE; leave a nonzero result before the reset test.
        issue8(1'b1, 8'h10, 8'h20, pk(0, 0, 8'h30));
        issue8(1'b1, 8'h7F, 8'h01, pk(1, 0, 8'h80));

        // Reset four edges into RUN aborts with no done.
        issue8(1'b1, 8'h11, 8'h22, pk(0, 0, 8'h33));
        repeat (4) @(posedge clk);
        #2 rst8 = 1'b1;
        q8.delete();
        #1;
        check("midrst_result", 32'(res8), 32'd0);
        check("midrst_cb", 32'(cb8), 32'd0);
        check("midrst_ovf", 32'(ovf8), 32'd0);
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_done", 32'(done8), 32'd0);
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        repeat (12) @(posedge clk);
        issue8(1'b0, 8'h40, 8'h0F, pk(0, 0, 8'h31));

        for (int i = 0; i < 150; i++) begin
            logic [7:0] x, y;
            bit m;
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            m = 1'($urandom_range(0, 1));
            issue8(m, x, y, model(8, m, longint'(x), longint'(y)));
        end

        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    issue4(1'(m), 4'(x), 4'(y), model(4, 1'(m), longint'(x), longint'(y)));

        t = 0;
        while ((q8.size() != 0 || q4.size() != 0) && t < 200) begin @(posedge clk); t++; end
        check("drain_q8", 32'(q8.size()), 32'd0);
        check("drain_q4", 32'(q4.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
